// File: rtl/ddc_iq_if.sv
// Sample/NCO input bundle and decimated I/Q output bundle for ddc_iq.
// The source (master) drives samples and the sink reads the output strobe.
interface ddc_iq_if;

    // Input side: adc_valid qualifies adc_data, dds_cos and dds_sin in the same cycle.
    // There is no backpressure. Every presented valid sample is accepted.
    logic signed [15:0] adc_data;
    logic               adc_valid;
    logic signed [15:0] dds_cos;
    logic signed [15:0] dds_sin;
    logic               dec_sync;

    // Output side: out_valid is a one-cycle strobe. The data outputs hold their value between strobes.
    logic signed [15:0] data_out_i;
    logic signed [15:0] data_out_q;
    logic               out_valid;

    modport master (
        output adc_data,
        output adc_valid,
        output dds_cos,
        output dds_sin,
        output dec_sync,
        input  data_out_i,
        input  data_out_q,
        input  out_valid
    );

    modport slave (
        input  adc_data,
        input  adc_valid,
        input  dds_cos,
        input  dds_sin,
        input  dec_sync,
        output data_out_i,
        output data_out_q,
        output out_valid
    );

endinterface

// File: rtl/ddc_iq.sv
// Digital down-converter: mixes real ADC samples with an NCO and integrates-and-dumps over 2^DEC_LOG2 samples.
// Optional macro DDC_IQ_ROUND_EN selects round-half-up at the dump instead of truncation.
module ddc_iq #(
    parameter int DEC_LOG2 = 3
) (
    input  logic        clk_200m,
    input  logic        cfg_rst_n,
    ddc_iq_if.slave     bus,
    output logic [63:0] debug
);

    localparam int AW = 32 + DEC_LOG2;
    localparam int LSB = 16 + DEC_LOG2;
    localparam logic [DEC_LOG2-1:0] CNT_LAST = '1;
    localparam logic [DEC_LOG2-1:0] CNT_ONE  = DEC_LOG2'(1);

    // Stage 1: mixer products and per-sample flags.
    logic signed [31:0] p_i;
    logic signed [31:0] p_q;
    logic               s1_valid;
    logic               s1_sync;

    // Stage 2: integrate-and-dump state.
    logic signed [AW-1:0]  acc_i;
    logic signed [AW-1:0]  acc_q;
    logic [DEC_LOG2-1:0]   cnt;

    // Combinational helpers for stage 2.
    logic signed [AW-1:0]  p_i_ext;
    logic signed [AW-1:0]  p_q_ext;
    logic signed [AW-1:0]  sum_i;
    logic signed [AW-1:0]  sum_q;
    logic signed [AW-1:0]  dump_i;
    logic signed [AW-1:0]  dump_q;
    logic                  is_dump;
    logic                  unused_lsbs;

    always_ff @(posedge clk_200m or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            p_i      <= '0;
            p_q      <= '0;
            s1_valid <= 1'b0;
            s1_sync  <= 1'b0;
        end else begin
            s1_valid <= bus.adc_valid;
            s1_sync  <= bus.dec_sync;
            if (bus.adc_valid) begin
                p_i <= 32'(bus.adc_data) * 32'(bus.dds_cos);
                p_q <= 32'(bus.adc_data) * 32'(bus.dds_sin);
            end
        end
    end

    always_comb begin
        p_i_ext = {{DEC_LOG2{p_i[31]}}, p_i};
        p_q_ext = {{DEC_LOG2{p_q[31]}}, p_q};
        sum_i   = acc_i + p_i_ext;
        sum_q   = acc_q + p_q_ext;
`ifdef DDC_IQ_ROUND_EN
        dump_i  = sum_i + (AW'(1) <<< (LSB - 1));
        dump_q  = sum_q + (AW'(1) <<< (LSB - 1));
`else
        dump_i  = sum_i;
        dump_q  = sum_q;
`endif
        is_dump = s1_valid && !s1_sync && (cnt == CNT_LAST);
    end

    // (sum >> DEC_LOG2)[31:16] is the top 16 bits of the accumulator-width sum.
    // The bits below that are discarded by design.
    assign unused_lsbs = ^{dump_i[LSB-1:0], dump_q[LSB-1:0]};

    always_ff @(posedge clk_200m or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            acc_i          <= '0;
            acc_q          <= '0;
            cnt            <= '0;
            bus.data_out_i <= '0;
            bus.data_out_q <= '0;
            bus.out_valid  <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (s1_sync) begin
                // The partial block is dropped. A coincident valid sample starts the new block.
                if (s1_valid) begin
                    acc_i <= p_i_ext;
                    acc_q <= p_q_ext;
                    cnt   <= CNT_ONE;
                end else begin
                    acc_i <= '0;
                    acc_q <= '0;
                    cnt   <= '0;
                end
            end else if (is_dump) begin
                bus.data_out_i <= dump_i[AW-1:LSB];
                bus.data_out_q <= dump_q[AW-1:LSB];
                bus.out_valid  <= 1'b1;
                acc_i          <= '0;
                acc_q          <= '0;
                cnt            <= '0;
            end else if (s1_valid) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                cnt   <= cnt + CNT_ONE;
            end
        end
    end

    assign debug = {acc_q[31:0], acc_i[31:0]};

endmodule

// File: tb/tb_ddc_iq.sv
// Directed plus randomized bench for ddc_iq. A block-level reference model predicts outputs, strobe timing and accumulator state.
module tb_ddc_iq;

  localparam int DEC_LOG2 = 3;
  localparam int N = 1 << DEC_LOG2;

  logic        clk_200m = 1'b0;
  logic        cfg_rst_n = 1'b0;
  logic [63:0] debug;

  ddc_iq_if bus();

  ddc_iq #(.DEC_LOG2(DEC_LOG2)) dut (
    .clk_200m (clk_200m),
    .cfg_rst_n(cfg_rst_n),
    .bus      (bus.slave),
    .debug    (debug)
  );

  // Clock and reset
  always #5 clk_200m = ~clk_200m;

  int checks = 0;
  int failures = 0;

  // Reference model state
  longint      blk_i[$];
  longint      blk_q[$];
  logic [31:0] exp_q[$];
  logic        pv[2];
  logic [31:0] pai[2];
  logic [31:0] paq[2];
  logic [15:0] hold_i;
  logic [15:0] hold_q;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] scale(input longint s);
    longint r;
`ifdef DDC_IQ_ROUND_EN
    s = s + (64'sd1 <<< (15 + DEC_LOG2));
`endif
    r = s >>> (16 + DEC_LOG2);
    return r[15:0];
  endfunction

  task automatic model_clear();
    blk_i.delete();
    blk_q.delete();
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      pv[k] = 1'b0;
      pai[k] = '0;
      paq[k] = '0;
    end
    hold_i = '0;
    hold_q = '0;
  endtask

  // Decide what the block does with one presented sample, then record the accumulator state expected two cycles later.
  task automatic model(input logic signed [15:0] adc, cos, sin, input logic valid, sync);
    longint si;
    longint sq;
    pv[1] = 1'b0;
    if (sync) begin
      blk_i.delete();
      blk_q.delete();
      if (valid) begin
        blk_i.push_back(longint'(adc) * longint'(cos));
        blk_q.push_back(longint'(adc) * longint'(sin));
      end
    end else if (valid) begin
      blk_i.push_back(longint'(adc) * longint'(cos));
      blk_q.push_back(longint'(adc) * longint'(sin));
      if (blk_i.size() == N) begin
        si = 0;
        sq = 0;
        foreach (blk_i[k]) si += blk_i[k];
        foreach (blk_q[k]) sq += blk_q[k];
        exp_q.push_back({scale(si), scale(sq)});
        blk_i.delete();
        blk_q.delete();
        pv[1] = 1'b1;
      end
    end
    si = 0;
    sq = 0;
    foreach (blk_i[k]) si += blk_i[k];
    foreach (blk_q[k]) sq += blk_q[k];
    pai[1] = si[31:0];
    paq[1] = sq[31:0];
  endtask

  task automatic observe();
    logic [31:0] e;
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, pv[0]});
    if (pv[0]) begin
      e = exp_q.pop_front();
      hold_i = e[31:16];
      hold_q = e[15:0];
    end
    chk("data_out_i", {48'd0, bus.data_out_i}, {48'd0, hold_i});
    chk("data_out_q", {48'd0, bus.data_out_q}, {48'd0, hold_q});
    chk("debug", debug, {paq[0], pai[0]});
    pv[0] = pv[1];
    pai[0] = pai[1];
    paq[0] = paq[1];
  endtask

  // Driver tasks
  task automatic step(input logic signed [15:0] adc, cos, sin, input logic valid, sync);
    @(negedge clk_200m);
    observe();
    model(adc, cos, sin, valid, sync);
    bus.adc_data = adc;
    bus.dds_cos = cos;
    bus.dds_sin = sin;
    bus.adc_valid = valid;
    bus.dec_sync = sync;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b0);
  endtask

  task automatic rand_sample(input logic valid, sync);
    step(16'($urandom), 16'($urandom), 16'($urandom), valid, sync);
  endtask

  task automatic do_reset();
    @(negedge clk_200m);
    bus.adc_data = '0;
    bus.dds_cos = '0;
    bus.dds_sin = '0;
    bus.adc_valid = 1'b0;
    bus.dec_sync = 1'b0;
    cfg_rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_data_i", {48'd0, bus.data_out_i}, 64'd0);
    chk("rst_data_q", {48'd0, bus.data_out_q}, 64'd0);
    chk("rst_debug", debug, 64'd0);
    model_clear();
    repeat (2) @(negedge clk_200m);
    cfg_rst_n = 1'b1;
  endtask

  initial begin
    bus.adc_data = '0;
    bus.dds_cos = '0;
    bus.dds_sin = '0;
    bus.adc_valid = 1'b0;
    bus.dec_sync = 1'b0;
    model_clear();
    do_reset();
    idle(2);

    // Eight constant samples: known I output, zero Q.
    repeat (N) step(16'sh4000, 16'sh7FFF, 16'sh0000, 1'b1, 1'b0);
    idle(3);
`ifdef DDC_IQ_ROUND_EN
    chk("fixed_i_half", {48'd0, bus.data_out_i}, 64'h2000);
`else
    chk("fixed_i_half", {48'd0, bus.data_out_i}, 64'h1FFF);
`endif
    chk("fixed_q_zero", {48'd0, bus.data_out_q}, 64'h0000);

    // Full-scale products.
    repeat (N) step(16'sh8000, 16'sh8000, 16'sh7FFF, 1'b1, 1'b0);
    idle(3);
    chk("full_scale_i", {48'd0, bus.data_out_i}, 64'h4000);
`ifdef DDC_IQ_ROUND_EN
    chk("full_scale_q", {48'd0, bus.data_out_q}, 64'hC001);
`else
    chk("full_scale_q", {48'd0, bus.data_out_q}, 64'hC000);
`endif

    // Valid gaps every other cycle.
    for (int k = 0; k < N; k++) begin
      step(16'sh4000, 16'sh7FFF, 16'sh0000, 1'b1, 1'b0);
      idle(1);
    end
    idle(3);

    // Five samples, then dec_sync with a valid sample, then seven more.
    repeat (5) rand_sample(1'b1, 1'b0);
    rand_sample(1'b1, 1'b1);
    repeat (N - 1) rand_sample(1'b1, 1'b0);
    idle(3);

    // dec_sync arrives on what would be the dump sample, then on an invalid cycle.
    repeat (N - 1) rand_sample(1'b1, 1'b0);
    rand_sample(1'b1, 1'b1);
    repeat (3) rand_sample(1'b1, 1'b0);
    rand_sample(1'b0, 1'b1);
    repeat (N) rand_sample(1'b1, 1'b0);
    idle(3);

    // Reset mid-block after four samples, then one clean block.
    repeat (4) rand_sample(1'b1, 1'b0);
    do_reset();
    repeat (N) rand_sample(1'b1, 1'b0);
    idle(4);

    // Randomized traffic with gaps and occasional syncs.
    for (int k = 0; k < 800; k++) begin
      rand_sample($urandom_range(0, 9) < 7, $urandom_range(0, 47) == 0);
    end
    idle(4);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddc_iq.md
DDC_IQ -- requirements
Module: ddc_iq

Interface
REQ-001 Parameter DEC_LOG2, default 3, sets decimation ratio N = 2^DEC_LOG2; legal range 1..6.
REQ-002 clk_200m  input  1  sole clock; all flops rising-edge.
REQ-003 cfg_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 adc_data  input  16  signed real input sample, two's complement.
REQ-005 adc_valid  input  1  qualifies adc_data, dds_cos, dds_sin in the same cycle.
REQ-006 dds_cos  input  16  signed NCO cosine, aligned with adc_data.
REQ-007 dds_sin  input  16  signed NCO sine, aligned with adc_data.
REQ-008 dec_sync  input  1  single-cycle pulse; restarts block alignment.
REQ-009 data_out_i  output  16  signed decimated I.
REQ-010 data_out_q  output  16  signed decimated Q.
REQ-011 out_valid  output  1  one-cycle strobe qualifying data_out_i/q.
REQ-012 debug  output  64  {acc_i[31:0] low word, acc_q[31:0] low word}, q in [63:32].

Function
REQ-013 Stage 1: on adc_valid=1, register p_i = adc_data*dds_cos and p_q = adc_data*dds_sin as full 32-bit signed products, plus a valid flag and dec_sync flag.
REQ-014 Stage 1 valid flag = adc_valid; when adc_valid=0 the products are not accumulated.
REQ-015 Stage 2: accumulators acc_i/acc_q, width 32+DEC_LOG2 signed, sign-extended adds, no wrap possible.
REQ-016 Sample counter, DEC_LOG2 bits, counts accepted (valid) samples 0..N-1, wraps N-1 -> 0.
REQ-017 On the valid sample with counter = N-1 (dump): data_out = ((acc + p) >> DEC_LOG2)[31:16], acc reloaded to 0, counter to 0, out_valid=1 next cycle.
REQ-018 Non-dump valid sample: acc <= acc + p, counter increments, out_valid=0.
REQ-019 Latency: out_valid high exactly 2 cycles after the cycle in which the N-th sample of a block is presented.
REQ-020 data_out_i/q hold their value between strobes; out_valid is a single-cycle pulse.
REQ-021 Gaps in adc_valid are allowed anywhere; they stall the block, never flush it.
REQ-022 dec_sync (flag in stage 2): partial block discarded; if that sample is valid it becomes sample 0 of the new block (acc <= p, counter <= 1), else acc <= 0, counter <= 0; no out_valid produced.
REQ-023 dec_sync coinciding with what would be a dump: sync wins, no output.
REQ-024 Scaling: full-scale product -32768*-32768 = 2^30 gives output 0x4000; output range never exceeds 16-bit signed, no saturation logic.

Reset
REQ-025 cfg_rst_n=0 asynchronously clears stage-1 registers, flags, acc_i, acc_q, counter, data_out_i, data_out_q, out_valid to 0.
REQ-026 After deassertion the first valid sample is sample 0 of a block; reset mid-block discards it without output.

Configuration
REQ-027 Macro DDC_IQ_ROUND_EN: when defined, dump adds 2^(15+DEC_LOG2) to (acc+p) before shift/slice (round half up); when undefined, plain truncation (floor).

Verification
REQ-028 DEC_LOG2=3, 8 valid samples adc=16384, cos=32767, sin=0 -> out_valid once, data_out_i=0x1FFF, data_out_q=0, 2 cycles after 8th sample.
REQ-029 adc=-32768, cos=-32768, sin=32767, 8 samples -> data_out_i=0x4000, data_out_q=0xC000 (truncate) / 0xC001 (DDC_IQ_ROUND_EN).
REQ-030 8 samples with adc_valid low every other cycle -> same result as REQ-028, strobe 2 cycles after final valid sample.
REQ-031 5 samples, dec_sync with valid sample, 7 more -> exactly one out_valid, after the 7th post-sync sample, value from the 8 post-sync samples.
REQ-032 cfg_rst_n pulsed low after 4 samples -> all outputs 0 immediately; next 8 samples give one correct output, no stray strobe.
